alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational alu instance between two requesters (port 0, port 1).
//  Round-robin arbitration with a valid/ready request handshake and a per-port held response.
//  Registers the granted operands and drives the alu from the registers.
//  Captures alu_output/zero one cycle after the grant.
//  Sits between the requesting units (e.g. main datapath, address/branch unit) and the alu.
// PARAMETERS
//  WIDTH   32  operand/result width; must match alu data width
//  FUNC_W  3   alu_function width
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  req_valid[i]  in   1       port i (i=0,1) request valid
//  req_ready[i]  out  1       port i request accepted this cycle when valid&ready
//  req_a[i]      in   WIDTH   port i operand a
//  req_b[i]      in   WIDTH   port i operand b
//  req_func[i]   in   FUNC_W  port i alu function code
//  rsp_valid[i]  out  1       port i result valid
//  rsp_ready[i]  in   1       port i consumes result when valid&ready
//  rsp_data      out  WIDTH   result (shared bus; qualify with rsp_valid[i])
//  rsp_zero      out  1       captured alu zero flag
//  alu_input_a   out  WIDTH   to alu input_a
//  alu_input_b   out  WIDTH   to alu input_b
//  alu_function  out  FUNC_W  to alu alu_function
//  alu_output    in   WIDTH   from alu
//  alu_zero      in   1       from alu zero
// BEHAVIOUR
//  Reset (async, rst_n=0), all values immediately:
//   - state=IDLE; all req_ready, rsp_valid = 0.
//   - rsp_data=0, rsp_zero=0; alu_input_a/b=0, alu_function=0.
//   - owner=0; last_grant=1 (port 0 wins first tie).
//  FSM:
//   - IDLE: req_ready[i]=1 only for the port chosen this cycle (combinational).
//     - If exactly one req_valid is high, choose that port.
//     - If both are high, choose the port != last_grant.
//     - On handshake: latch req_a/b/func into alu_input_* regs, owner<=port,
//       last_grant<=port, go to EXEC.
//     - If no request, stay in IDLE; alu_input_* hold their last values.
//   - EXEC (1 cycle): alu settles on the registered inputs.
//     - rsp_data<=alu_output, rsp_zero<=alu_zero, rsp_valid[owner]<=1, go to RESP.
//   - RESP: hold rsp_data/rsp_zero/rsp_valid[owner] stable until rsp_ready[owner]=1.
//     - Then clear rsp_valid and go to IDLE.
//     - rsp_ready of the non-owner port is ignored.
//   - req_ready=0 in EXEC and RESP; no new request is accepted in these states.
//  Latency and throughput:
//   - Accept in cycle t; rsp_valid high from cycle t+2.
//   - Minimum 3 cycles per operation: next accept earliest in the cycle after rsp handshake.
//  Requester rules:
//   - Once valid, a requester holds req_valid and its operands stable until req_ready.
//   - The arbiter never drops an accepted request.
//  Fairness: with both ports requesting continuously, grants alternate 0,1,0,1...
//  Width and flags: data passes through unmodified. No arithmetic in this block.
//   - Undefined function codes return the alu's 0 result; rsp_zero=1.
//  Reset mid-operation: an in-flight op is discarded; rsp_valid never asserts for it.
//  At most one rsp_valid bit is high at any time. req_ready is one-hot or zero.
// TESTING
//  1. Reset: rst_n=0 mid-EXEC -> rsp_valid=0 at once; after release, port 0 wins the first tie.
//  2. Single op: p0 a=5 b=3 func=000 at t -> rsp_valid[0] at t+2, rsp_data=8, rsp_zero=0.
//  3. Tie and alternation: both ports valid continuously (p0 func=001 a=7 b=7,
//     p1 func=011 a=0xF0 b=0x0F), rsp_ready=1:
//     grants p0,p1,p0; results 0 (zero=1), 0xFF (zero=0), 0 (zero=1); one op per 3 cycles.
//  4. Backpressure: hold rsp_ready[1]=0 for 5 cycles after rsp_valid[1] ->
//     rsp_data stable; p0 req_ready=0 throughout; p0 accepted the cycle after release.
//  5. Boundary: func=100 a=0 b=0xFFFFFFFF -> 1.
//     func=000 a=0xFFFFFFFF b=1 -> 0 with rsp_zero=1 (wrap).
//     func=111 -> 0, rsp_zero=1.
//  6. Stability: p1 changes req_a while stalled in EXEC/RESP -> response uses the value latched at accept.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Lets two requesters share one combinational ALU. Arbitration between the two
// ports is round-robin. The operands of the granted request are registered and
// drive the ALU from those registers. The ALU result is captured one cycle
// later and held for the owning port until that port consumes it.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*WIDTH-1:0]    req_a,
    input  logic [2*WIDTH-1:0]    req_b,
    input  logic [2*FUNC_W-1:0]   req_func,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_zero,
    output logic [WIDTH-1:0]      alu_input_a,
    output logic [WIDTH-1:0]      alu_input_b,
    output logic [FUNC_W-1:0]     alu_function,
    input  logic [WIDTH-1:0]      alu_output,
    input  logic                  alu_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic              last_grant;
    logic              any_req;
    logic              pick;
    logic              accept;
    logic              consume;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [FUNC_W-1:0] sel_func;

    // Round-robin choice: a lone requester always wins; on a tie the port
    // that was not granted last time wins.
    function automatic logic pick_port(input logic [1:0] valid, input logic last);
        logic p;
        if (valid == 2'b11) begin
            p = ~last;
        end else begin
            p = valid[1];
        end
        return p;
    endfunction

    // Port select, ready generation and handshake decode (ready is held low
    // while reset is asserted so nothing is handed over during reset).
    always_comb begin
        any_req  = |req_valid;
        pick     = pick_port(req_valid, last_grant);
        sel_a    = pick ? req_a[2*WIDTH-1:WIDTH]      : req_a[WIDTH-1:0];
        sel_b    = pick ? req_b[2*WIDTH-1:WIDTH]      : req_b[WIDTH-1:0];
        sel_func = pick ? req_func[2*FUNC_W-1:FUNC_W] : req_func[FUNC_W-1:0];
        req_ready = 2'b00;
        if (rst_n && (state == IDLE) && any_req) begin
            req_ready = pick ? 2'b10 : 2'b01;
        end
        accept  = (state == IDLE) && any_req;
        consume = (state == RESP) && rsp_ready[owner];
    end

    // Control FSM: IDLE -> EXEC on accept, EXEC -> RESP after one settle
    // cycle, RESP -> IDLE once the owner takes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= pick;
                        last_grant <= pick;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    state <= RESP;
                end
                RESP: begin
                    if (consume) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand registers feeding the ALU; they keep their last values while
    // idle so the ALU inputs do not toggle needlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_input_a  <= '0;
            alu_input_b  <= '0;
            alu_function <= '0;
        end else if (accept) begin
            alu_input_a  <= sel_a;
            alu_input_b  <= sel_b;
            alu_function <= sel_func;
        end
    end

    // Result capture at the end of the settle cycle and the per-port held
    // response; only the owner's rsp_ready can release it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_valid <= 2'b00;
        end else begin
            if (state == EXEC) begin
                rsp_data  <= alu_output;
                rsp_zero  <= alu_zero;
                rsp_valid <= owner ? 2'b10 : 2'b01;
            end else if (consume) begin
                rsp_valid <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [5:0]  req_func;
    logic [31:0] rsp_data, alu_input_a, alu_input_b, alu_output;
    logic        rsp_zero, alu_zero;
    logic [2:0]  alu_function;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .FUNC_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_func(req_func),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .alu_input_a(alu_input_a), .alu_input_b(alu_input_b),
        .alu_function(alu_function),
        .alu_output(alu_output), .alu_zero(alu_zero)
    );

    // ALU behaviour: 000 add, 001 sub, 010 and, 011 or, 100 unsigned less-than,
    // 101 xor, anything else returns 0. Result bit 32 is the zero flag.
    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        logic [31:0] r;
        case (f)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = (a < b) ? 32'd1 : 32'd0;
            3'b101:  r = a ^ b;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    // Combinational ALU sitting behind the arbiter.
    always_comb begin
        {alu_zero, alu_output} = ref_alu(alu_input_a, alu_input_b, alu_function);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int p, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] f);
        req_valid[p]        = 1'b1;
        req_a[p*32 +: 32]   = a;
        req_b[p*32 +: 32]   = b;
        req_func[p*3 +: 3]  = f;
    endtask

    // Waits (bounded) for the cycle in which port p is accepted.
    task automatic wait_ready(input int p, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_accept"}, ok, 1);
    endtask

    // Counts cycles after the accept cycle until rsp_valid[p] is seen.
    task automatic wait_rsp(input int p, output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid[p]) begin
                lat = i;
                break;
            end
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] d;
        logic        z;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] d;
        logic        z;
        int          acc_cyc;
        bit          seen;
    } exp_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        int          lat;
        logic [31:0] held;
        int          g_port[$];
        int          g_cyc[$];
        logic [32:0] r_val[$];
        int          r_port[$];
        exp_t        q[$];
        exp_t        e;
        logic        last_g;
        logic [1:0]  pred;
        bit          acc[2];
        int          p;
        logic [32:0] rr;

        vecs[0] = '{0, 32'd5,          32'd3,          3'b000, 32'd8,          1'b0};
        vecs[1] = '{0, 32'd0,          32'hFFFF_FFFF,  3'b100, 32'd1,          1'b0};
        vecs[2] = '{1, 32'hFFFF_FFFF,  32'd1,          3'b000, 32'd0,          1'b1};
        vecs[3] = '{1, 32'd123,        32'd456,        3'b111, 32'd0,          1'b1};
        vecs[4] = '{0, 32'hAAAA_0000,  32'h0000_FFFF,  3'b011, 32'hAAAA_FFFF,  1'b0};
        vecs[5] = '{1, 32'd10,         32'd3,          3'b001, 32'd7,          1'b0};
        vecs[6] = '{0, 32'd0,          32'd1,          3'b001, 32'hFFFF_FFFF,  1'b0};
        vecs[7] = '{1, 32'h0000_FF00,  32'h0000_0F0F,  3'b010, 32'h0000_0F00,  1'b0};

        // Reset state, with both requesters asking so ready gating is visible.
        rst_n = 1'b0; rsp_ready = 2'b11;
        req_valid = 2'b00; req_a = '0; req_b = '0; req_func = '0;
        drive_req(0, 32'd1, 32'd2, 3'b000);
        drive_req(1, 32'd3, 32'd4, 3'b000);
        #3;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_zero", rsp_zero, 0);
        check("rst_alu_a", alu_input_a, 0);
        check("rst_alu_f", alu_function, 0);
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vector table, one isolated operation each.
        foreach (vecs[i]) begin
            drive_req(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].f);
            wait_ready(vecs[i].port, $sformatf("vec%0d", i));
            @(posedge clk); #1;
            req_valid[vecs[i].port] = 1'b0;
            wait_rsp(vecs[i].port, lat);
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_data", i), rsp_data, vecs[i].d);
            check($sformatf("vec%0d_zero", i), rsp_zero, vecs[i].z);
            @(posedge clk); #1;
        end

        // Reset in the middle of EXEC discards the operation.
        drive_req(0, 32'd9, 32'd9, 3'b000);
        wait_ready(0, "midrst");
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2 rst_n = 1'b0;
        drive_req(0, 32'd7, 32'd7, 3'b001);
        drive_req(1, 32'h0000_00F0, 32'h0000_000F, 3'b011);
        #1;
        check("midrst_rsp_valid", rsp_valid, 2'b00);
        check("midrst_req_ready", req_ready, 2'b00);
        check("midrst_rsp_data", rsp_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Both ports continuously valid: p0 wins the first tie, then alternate.
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                g_port.push_back(int'(req_ready[1]));
                g_cyc.push_back(cyc);
            end
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                r_port.push_back(int'(rsp_valid[1]));
                r_val.push_back({rsp_zero, rsp_data});
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("alt_grant_count", g_port.size(), 4);
        check("alt_result_count", r_val.size(), 4);
        if (g_port.size() >= 3 && r_val.size() >= 3) begin
            check("alt_grant0", g_port[0], 0);
            check("alt_grant1", g_port[1], 1);
            check("alt_grant2", g_port[2], 0);
            check("alt_gap1", g_cyc[1] - g_cyc[0], 3);
            check("alt_gap2", g_cyc[2] - g_cyc[1], 3);
            check("alt_rport0", r_port[0], 0);
            check("alt_rport1", r_port[1], 1);
            check("alt_res0", r_val[0], {1'b1, 32'd0});
            check("alt_res1", r_val[1], {1'b0, 32'h0000_00FF});
            check("alt_res2", r_val[2], {1'b1, 32'd0});
        end

        // Backpressure on port 1 while port 0 waits.
        rsp_ready = 2'b01;
        drive_req(1, 32'd20, 32'd22, 3'b000);
        wait_ready(1, "bp_p1");
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drive_req(0, 32'd1, 32'd2, 3'b000);
        wait_rsp(1, lat);
        check("bp_latency", lat, 2);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("bp_valid%0d", k), rsp_valid, 2'b10);
            check($sformatf("bp_data%0d", k), rsp_data, 32'd42);
            check($sformatf("bp_p0ready%0d", k), req_ready, 2'b00);
        end
        @(posedge clk); #1 rsp_ready = 2'b11;
        @(negedge clk);
        check("bp_release_valid", rsp_valid, 2'b10);
        check("bp_release_ready", req_ready, 2'b00);
        @(negedge clk);
        check("bp_p0_accept", req_ready, 2'b01);
        check("bp_cleared", rsp_valid, 2'b00);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(0, lat);
        check("bp_p0_latency", lat, 2);
        check("bp_p0_data", rsp_data, 32'd3);
        @(posedge clk); #1;

        // Operands changed after acceptance must not affect the result.
        rsp_ready = 2'b01;
        drive_req(1, 32'd10, 32'd4, 3'b001);
        wait_ready(1, "stab");
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_a[63:32] = 32'd100;
        req_b[63:32] = 32'd50;
        wait_rsp(1, lat);
        check("stab_data", rsp_data, 32'd6);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            req_a[63:32] = $urandom;
            @(negedge clk);
            check($sformatf("stab_hold%0d", k), rsp_data, 32'd6);
        end
        @(posedge clk); #1 rsp_ready = 2'b11;
        @(posedge clk); #1;

        // Randomized traffic against a transaction-level model.
        rst_n = 1'b0;
        req_valid = 2'b00;
        @(posedge clk); #1 rst_n = 1'b1;
        last_g = 1'b1;
        acc[0] = 1'b0; acc[1] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int pp = 0; pp < 2; pp++) begin
                logic [31:0] a, b;
                a = $urandom;
                b = ($urandom_range(3) == 0) ? a : $urandom;
                if (req_valid[pp]) begin
                    if (acc[pp]) begin
                        if ($urandom_range(1) == 1) drive_req(pp, a, b, 3'($urandom_range(7)));
                        else req_valid[pp] = 1'b0;
                    end
                end else if ($urandom_range(2) == 0) begin
                    drive_req(pp, a, b, 3'($urandom_range(7)));
                end
                acc[pp] = 1'b0;
            end
            rsp_ready = 2'($urandom_range(3));
            @(negedge clk);
            if (q.size() == 0) begin
                pred = (req_valid == 2'b11) ? (last_g ? 2'b01 : 2'b10) : req_valid;
                check("rnd_ready", req_ready, pred);
                check("rnd_idle_rsp", rsp_valid, 2'b00);
                if ((req_ready & req_valid) != 2'b00) begin
                    p = req_ready[1] ? 1 : 0;
                    acc[p] = 1'b1;
                    last_g = p[0];
                    rr = ref_alu(req_a[p*32 +: 32], req_b[p*32 +: 32], req_func[p*3 +: 3]);
                    q.push_back('{p, rr[31:0], rr[32], cyc, 1'b0});
                end
            end else begin
                e = q[0];
                check("rnd_busy_ready", req_ready, 2'b00);
                if (rsp_valid != 2'b00) begin
                    check("rnd_rsp_port", rsp_valid, e.port ? 2'b10 : 2'b01);
                    check("rnd_rsp_data", rsp_data, e.d);
                    check("rnd_rsp_zero", rsp_zero, e.z);
                    if (!e.seen) check("rnd_latency", cyc - e.acc_cyc, 2);
                    q[0].seen = 1'b1;
                    if (rsp_ready[e.port]) void'(q.pop_front());
                end else begin
                    check("rnd_rsp_missing", (cyc - e.acc_cyc) < 2, 1);
                end
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
